// File: rtl/text_pkg.sv
// text_pkg: shared constants, state encoding and address helper for the
// text console. Screen geometry is 160 columns x 50 rows of 8x16 glyphs
// (1280x800 pixels), so the character store holds 8000 cells addressed as
// row*COLS + col in 13 bits.
package text_pkg;

  localparam int COLS   = 160;
  localparam int ROWS   = 50;
  localparam int NCELL  = COLS * ROWS;
  localparam int ADDR_W = 13;

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // Sized limits so comparisons against the narrow cursor/read fields stay
  // width-matched.
  localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
  localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELL - 1);

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    LINE_CLR = 2'd2
  } state_t;

  // Linear cell address. Callers only pass in-range row/col, so the result
  // never exceeds LAST_ADDR (49*160 + 159 = 7999).
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                  input logic [7:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_char_ram.sv
// text_char_ram: simple dual-port 8000x8 character store.
//   clk     : write and read clock (posedge)
//   i_we    : write enable
//   i_waddr : write address, 0..7999
//   i_wdata : write data
//   i_raddr : read address, 0..7999
//   o_rdata : registered read data, valid one cycle after i_raddr
// A write and a read of the same address in one cycle return the old
// contents (read-before-write). No reset on the array or the output
// register so the store maps onto block RAM.
module text_char_ram
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:NCELL-1];
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/text_console.sv
// text_console: character-stream front end for the 1280x800 text display.
// Interprets an ASCII byte stream, keeps a cursor and stores characters in
// a 160x50 cell buffer that the text renderer reads back.
//   clk        : system clock, posedge
//   reset      : asynchronous, active-low
//   in_valid   : in_data holds a character
//   in_data    : ASCII code
//   in_ready   : block accepts in_data this cycle
//   rd_col     : read column (>= 160 reads BLANK)
//   rd_row     : read row (>= 50 reads BLANK)
//   rd_data    : character at (rd_row, rd_col), one cycle after the address
//   cursor_col : current cursor column
//   cursor_row : current cursor row
//   busy       : high while a full-screen or line clear is sweeping
//   state_dbg  : current FSM state (text_pkg::state_t encoding)
//
// Handshake: a character transfers on every rising edge where in_valid and
// in_ready are both high. in_ready is a register that depends only on the
// FSM state, never on in_valid; the source may hold in_valid high and
// stream one character per cycle while in_ready stays high.
module text_console
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] rd_col,
  input  logic [5:0] rd_row,
  output logic [7:0] rd_data,
  output logic [7:0] cursor_col,
  output logic [5:0] cursor_row,
  output logic       busy,
  output logic [1:0] state_dbg
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [7:0]        r_lc_col;
  logic [7:0]        r_cur_col;
  logic [5:0]        r_cur_row;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_rd_oob;
  logic              r_rd_live;

  logic              w_accept;
  logic              w_is_print;
  logic              w_row_adv;
  logic [5:0]        w_next_row;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;
  logic              w_rd_oob;
  logic [ADDR_W-1:0] w_raddr;
  logic [7:0]        w_ram_q;

  // ---------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------
  assign w_accept   = in_valid & r_in_ready;
  assign w_is_print = (in_data >= PRINT_LO) && (in_data <= PRINT_HI);

  // A printable character in the last column and LF both move to the next
  // row (wrapping 49 -> 0, no scrolling) and trigger a clear of that row.
  assign w_row_adv  = w_accept &&
                      ((w_is_print && (r_cur_col == LAST_COL)) || (in_data == LF));
  assign w_next_row = (r_cur_row == LAST_ROW) ? 6'd0 : r_cur_row + 6'd1;

  // ---------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_addr;
    w_wdata = BLANK;
    case (r_state)
      CLEAR: begin
        w_we = 1'b1;
      end
      LINE_CLR: begin
        // r_cur_row already holds the new row during the sweep.
        w_we    = 1'b1;
        w_waddr = cell_addr(r_cur_row, r_lc_col);
      end
      IDLE: begin
        if (w_accept) begin
          if (w_is_print) begin
            w_we    = 1'b1;
            w_waddr = cell_addr(r_cur_row, r_cur_col);
            w_wdata = in_data;
          end else if ((in_data == BS) && (r_cur_col != 8'd0)) begin
            // Backspace blanks the cell the cursor moves back onto.
            w_we    = 1'b1;
            w_waddr = cell_addr(r_cur_row, r_cur_col - 8'd1);
          end
        end
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM, cursor and sweep counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_lc_col   <= 8'd0;
      r_cur_col  <= 8'd0;
      r_cur_row  <= 6'd0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + 13'd1;
          end
        end

        IDLE: begin
          if (w_accept) begin
            if (w_is_print) begin
              r_cur_col <= (r_cur_col == LAST_COL) ? 8'd0 : r_cur_col + 8'd1;
            end else if ((in_data == LF) || (in_data == CR)) begin
              r_cur_col <= 8'd0;
            end else if (in_data == BS) begin
              if (r_cur_col != 8'd0) begin
                r_cur_col <= r_cur_col - 8'd1;
              end
            end else if (in_data == FF) begin
              r_cur_col  <= 8'd0;
              r_cur_row  <= 6'd0;
              r_clr_addr <= '0;
              r_state    <= CLEAR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
            // Other codes are consumed without effect.

            if (w_row_adv) begin
              r_cur_row  <= w_next_row;
              r_lc_col   <= 8'd0;
              r_state    <= LINE_CLR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end

        LINE_CLR: begin
          if (r_lc_col == LAST_COL) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_lc_col <= r_lc_col + 8'd1;
          end
        end

        default: begin
          r_state    <= CLEAR;
          r_clr_addr <= '0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------
  // Out-of-range coordinates are steered to address 0 so the RAM never sees
  // an address past 7999; the registered flag substitutes BLANK afterwards.
  assign w_rd_oob = (rd_col > LAST_COL) || (rd_row > LAST_ROW);
  assign w_raddr  = w_rd_oob ? '0 : cell_addr(rd_row, rd_col);

  // The RAM output register has no reset, so r_rd_live forces rd_data to
  // 0x00 from reset until the first post-reset read has been clocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_oob  <= 1'b0;
      r_rd_live <= 1'b0;
    end else begin
      r_rd_oob  <= w_rd_oob;
      r_rd_live <= 1'b1;
    end
  end

  text_char_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  assign rd_data    = !r_rd_live ? 8'h00 : (r_rd_oob ? BLANK : w_ram_q);
  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign cursor_col = r_cur_col;
  assign cursor_row = r_cur_row;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

  localparam int COLS  = 160;
  localparam int ROWS  = 50;
  localparam int NCELL = 8000;
  localparam logic [7:0] BLANK = 8'h20;
  localparam int BOUND = 9000;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] rd_col = 8'd0;
  logic [5:0] rd_row = 6'd0;
  logic [7:0] rd_data;
  logic [7:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  text_console dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Screen as a flat array plus a cursor; every character takes effect
  // immediately, and the function returns how many cycles the block should
  // refuse input afterwards.
  logic [7:0] mdl_mem [NCELL];
  int m_row = 0;
  int m_col = 0;

  function automatic void model_blank_all();
    for (int i = 0; i < NCELL; i++) mdl_mem[i] = BLANK;
  endfunction

  function automatic int model_next_line();
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) mdl_mem[m_row * COLS + c] = BLANK;
    return COLS;
  endfunction

  function automatic int model_apply(input logic [7:0] ch);
    int st;
    st = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      mdl_mem[m_row * COLS + m_col] = ch;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        st = model_next_line();
      end
    end else if (ch == 8'h0A) begin
      m_col = 0;
      st = model_next_line();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        mdl_mem[m_row * COLS + m_col] = BLANK;
      end
    end else if (ch == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      model_blank_all();
      st = NCELL;
    end
    return st;
  endfunction

  // ---------------- driver tasks ----------------
  // Count negedges with in_ready low, stopping at the first one with it high.
  task automatic wait_ready(output int stalls);
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < BOUND) begin
      stalls++;
      @(negedge clk);
    end
  endtask

  // Send one character; also reads the cursor cell on the accept edge
  // (must return the pre-write value) and compares stall and cursor.
  task automatic send(input logic [7:0] ch, output int st);
    int w;
    int st_exp;
    logic [7:0] old;
    wait_ready(w);
    if (w >= BOUND) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready low %0d cycles before sending %02h", w, ch);
    end
    old    = mdl_mem[m_row * COLS + m_col];
    rd_row = 6'(m_row);
    rd_col = 8'(m_col);
    in_valid = 1'b1;
    in_data  = ch;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("read_before_write", {24'd0, rd_data}, {24'd0, old});
    st_exp = model_apply(ch);
    wait_ready(st);
    check("stall_cycles", st, st_exp);
    check("cursor_row", {26'd0, cursor_row}, m_row);
    check("cursor_col", {24'd0, cursor_col}, m_col);
  endtask

  task automatic rd_check(input int row, input int col, input logic [7:0] exp, input string name);
    @(negedge clk);
    rd_row = 6'(row);
    rd_col = 8'(col);
    @(posedge clk);
    #1 check(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic count_clear(input string name);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    @(negedge clk);
    while (!in_ready && cnt < BOUND) begin
      if (!busy) bad++;
      cnt++;
      @(negedge clk);
    end
    check({name, "_cycles"}, cnt, NCELL);
    check({name, "_busy_low_cycles"}, bad, 0);
    check({name, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  task automatic send_n(input logic [7:0] ch, input int n);
    int st;
    for (int i = 0; i < n; i++) send(ch, st);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] ch;
    int         row;
    int         col;
    int         stall;
  } vec_t;

  vec_t vt [8];

  initial begin
    int st;
    int acc;
    logic [7:0] hola [4];
    logic [7:0] ch;
    int r;
    int rr;
    int cc;

    vt[0] = '{8'h08, 0, 0, 0};
    vt[1] = '{8'h41, 0, 1, 0};
    vt[2] = '{8'h42, 0, 2, 0};
    vt[3] = '{8'h08, 0, 1, 0};
    vt[4] = '{8'h0C, 0, 0, 8000};
    vt[5] = '{8'h07, 0, 0, 0};
    vt[6] = '{8'h31, 0, 1, 0};
    vt[7] = '{8'h0D, 0, 0, 0};
    hola[0] = 8'h48; hola[1] = 8'h4F; hola[2] = 8'h4C; hola[3] = 8'h41;

    // ---- reset values ----
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_cursor_col", {24'd0, cursor_col}, 0);
    check("rst_cursor_row", {26'd0, cursor_row}, 0);
    check("rst_rd_data", {24'd0, rd_data}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_blank_all();
    m_row = 0;
    m_col = 0;
    count_clear("init_clear");
    rd_check(0, 0, BLANK, "clear_0_0");
    rd_check(49, 159, BLANK, "clear_49_159");
    rd_check(25, 80, BLANK, "clear_25_80");

    // ---- back-to-back HOLA ----
    @(negedge clk);
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = hola[k];
      acc += int'(in_ready);
      @(posedge clk);
      #1;
      st = model_apply(hola[k]);
    end
    in_valid = 1'b0;
    check("hola_accepts", acc, 4);
    check("hola_cursor_col", {24'd0, cursor_col}, 4);
    check("hola_cursor_row", {26'd0, cursor_row}, 0);
    for (int k = 0; k < 4; k++) rd_check(0, k, hola[k], "hola_cell");

    // ---- wrap at last column into a pre-filled row ----
    send_n(8'h0A, 4);
    send(8'h5A, st);
    rd_check(4, 0, 8'h5A, "prefill_z");
    send_n(8'h0A, ROWS - 1);
    for (int k = 0; k < COLS - 1; k++) send(8'($urandom_range(8'h21, 8'h7E)), st);
    check("pre_x_row", {26'd0, cursor_row}, 3);
    check("pre_x_col", {24'd0, cursor_col}, 159);
    send(8'h58, st);
    check("x_stall", st, 160);
    check("x_cursor_row", {26'd0, cursor_row}, 4);
    check("x_cursor_col", {24'd0, cursor_col}, 0);
    rd_check(3, 159, 8'h58, "x_cell");
    for (int c = 0; c < COLS; c++) rd_check(4, c, BLANK, "row4_blank");

    // ---- LF on the last row wraps to row 0 ----
    send_n(8'h0A, 45);
    for (int k = 0; k < 10; k++) send(8'h2E, st);
    check("pre_lf_row", {26'd0, cursor_row}, 49);
    check("pre_lf_col", {24'd0, cursor_col}, 10);
    send(8'h0A, st);
    check("wrap_row", {26'd0, cursor_row}, 0);
    check("wrap_col", {24'd0, cursor_col}, 0);
    for (int c = 0; c < COLS; c++) rd_check(0, c, BLANK, "row0_blank");

    // ---- table: BS at col 0, A B BS, FF, other code, CR ----
    for (int i = 0; i < 8; i++) begin
      send(vt[i].ch, st);
      check("vec_stall", st, vt[i].stall);
      check("vec_row", {26'd0, cursor_row}, vt[i].row);
      check("vec_col", {24'd0, cursor_col}, vt[i].col);
      if (i == 3) begin
        rd_check(0, 1, BLANK, "bs_cell_0_1");
        rd_check(0, 0, 8'h41, "bs_cell_0_0");
      end
      if (i == 4) begin
        for (int k = 0; k < 30; k++)
          rd_check($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), BLANK, "ff_blank");
        rd_check(3, 159, BLANK, "ff_blank_x");
      end
      if (i == 5) rd_check(0, 0, BLANK, "bel_no_write");
      if (i == 7) rd_check(0, 0, 8'h31, "cr_kept_cell");
    end

    // ---- randomized stream against the model ----
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) ch = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 78) ch = 8'h0D;
      else if (r < 88) ch = 8'h08;
      else if (r < 93) ch = 8'h0A;
      else if (r < 96) ch = 8'($urandom_range(8'h7F, 8'hFF));
      else begin
        ch = 8'h00;
        for (int t = 0; t < 8; t++) begin
          ch = 8'($urandom_range(0, 31));
          if (ch != 8'h08 && ch != 8'h0A && ch != 8'h0C && ch != 8'h0D) break;
          ch = 8'h1B;
        end
      end
      send(ch, st);
    end
    for (int k = 0; k < 80; k++) begin
      rr = (k < 20) ? m_row : $urandom_range(0, ROWS - 1);
      cc = $urandom_range(0, COLS - 1);
      rd_check(rr, cc, mdl_mem[rr * COLS + cc], "rand_cell");
    end
    rd_check(0, 200, BLANK, "oob_col");
    rd_check(55, 5, BLANK, "oob_row");
    rd_check(63, 255, BLANK, "oob_both");
    rd_check(10, 160, BLANK, "oob_col_edge");

    // ---- reset in the middle of a line clear ----
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h0A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("lc_busy_before_rst", {31'd0, busy}, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 0);
    check("arst_busy", {31'd0, busy}, 1);
    check("arst_cursor_col", {24'd0, cursor_col}, 0);
    check("arst_cursor_row", {26'd0, cursor_row}, 0);
    check("arst_rd_data", {24'd0, rd_data}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_blank_all();
    m_row = 0;
    m_col = 0;
    count_clear("rst_clear");
    for (int k = 0; k < 20; k++)
      rd_check($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), BLANK, "rst_blank");
    send(8'h4B, st);
    rd_check(0, 0, 8'h4B, "post_rst_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit in case a bounded wait is ever bypassed.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
